// File: rtl/iis_tx_feeder.sv
// ----------------------------------------------------------------------------
// iis_tx_feeder
// Stereo sample FIFO that feeds an IIS transmitter. A producer pushes
// {left, right} pairs through a valid/ready handshake. Each single-cycle
// data_rd request from the transmitter pops the head pair into the data_l /
// data_r output registers, where the new pair is visible in the next cycle.
// A request that finds the FIFO empty is an underrun. It raises a one-cycle
// pulse and bumps a saturating event counter.
//
// Build option:
//   IIS_TX_FEEDER_HOLD_LAST_EN
//     defined   : an underrun repeats the last popped pair
//     undefined : an underrun outputs silence (0/0)
//
// Ports:
//   mck          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_left      in   32-bit signed left sample
//   in_right     in   32-bit signed right sample
//   in_valid     in   producer offers a pair
//   in_ready     out  FIFO can accept a pair (registered)
//   data_rd      in   frame request from the transmitter
//   data_l       out  left sample to the transmitter
//   data_r       out  right sample to the transmitter
//   level        out  number of stored pairs, 0..DEPTH
//   underrun     out  one-cycle pulse after a request that found no data
//   underrun_cnt out  saturating underrun event count
// ----------------------------------------------------------------------------
module iis_tx_feeder #(
   parameter int DEPTH = 16
) (
   input  logic                         mck,
   input  logic                         rst,
   input  logic signed [31:0]           in_left,
   input  logic signed [31:0]           in_right,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         data_rd,
   output logic signed [31:0]           data_l,
   output logic signed [31:0]           data_r,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         underrun,
   output logic [15:0]                  underrun_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [63:0]          r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [LW-1:0]        r_level;
   logic                 r_in_ready;
   logic signed [31:0]   r_data_l;
   logic signed [31:0]   r_data_r;
   logic                 r_underrun;
   logic [15:0]          r_underrun_cnt;

   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_under;
   logic [LW-1:0]        w_level_nxt;
   logic [63:0]          w_head;
   logic [63:0]          w_data_nxt;

   // The handshake uses only registered readiness, so in_ready never depends on in_valid or data_rd.
   assign w_empty = (r_level == LW'(0));
   assign w_push  = in_valid & r_in_ready;
   assign w_pop   = data_rd & ~w_empty;
   assign w_under = data_rd & w_empty;
   assign w_head  = r_mem[r_rd_ptr];

   // Compute the next fill level. Push and pop in the same cycle cancel.
   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LW'(1);
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - LW'(1);
      end else begin
         w_level_nxt = r_level;
      end
   end

   // Select the next output pair: the popped head, underrun fill, or hold.
   always_comb begin
      w_data_nxt = {r_data_l, r_data_r};
      if (w_pop) begin
         w_data_nxt = w_head;
      end else if (w_under) begin
`ifdef IIS_TX_FEEDER_HOLD_LAST_EN
         w_data_nxt = {r_data_l, r_data_r};
`else
         w_data_nxt = 64'd0;
`endif
      end else begin
         w_data_nxt = {r_data_l, r_data_r};
      end
   end

   // Pair storage. It has no reset because contents are only read below level.
   always_ff @(posedge mck) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= {in_left, in_right};
      end
   end

   // Pointers, level, ready flag, output pair, and underrun tracking.
   always_ff @(posedge mck) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_level        <= '0;
         r_in_ready     <= 1'b1;
         r_data_l       <= 32'sd0;
         r_data_r       <= 32'sd0;
         r_underrun     <= 1'b0;
         r_underrun_cnt <= 16'd0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level    <= w_level_nxt;
         r_in_ready <= (w_level_nxt != LW'(DEPTH));
         r_data_l   <= w_data_nxt[63:32];
         r_data_r   <= w_data_nxt[31:0];
         r_underrun <= w_under;
         if (w_under && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
         end
      end
   end

   assign in_ready     = r_in_ready;
   assign data_l       = r_data_l;
   assign data_r       = r_data_r;
   assign level        = r_level;
   assign underrun     = r_underrun;
   assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_iis_tx_feeder.sv
// ----------------------------------------------------------------------------
// tb_iis_tx_feeder
// Self-checking bench for iis_tx_feeder with DEPTH=16. A queue-based model
// tracks the stored pairs, the output pair, the underrun pulse and the
// counter. One compare process checks every DUT output against the model on
// each falling edge. Directed scenarios add literal expectations, and a
// randomized phase follows.
// ----------------------------------------------------------------------------
module tb_iis_tx_feeder;

   localparam int DEPTH = 16;

   logic                mck;
   logic                rst;
   logic signed [31:0]  in_left;
   logic signed [31:0]  in_right;
   logic                in_valid;
   logic                in_ready;
   logic                data_rd;
   logic signed [31:0]  data_l;
   logic signed [31:0]  data_r;
   logic [4:0]          level;
   logic                underrun;
   logic [15:0]         underrun_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [63:0]         q[$];
   logic signed [31:0]  e_l;
   logic signed [31:0]  e_r;
   logic                e_und;
   logic [15:0]         e_cnt;
   bit                  m_on = 1'b0;

   iis_tx_feeder #(.DEPTH(DEPTH)) dut (
      .mck          (mck),
      .rst          (rst),
      .in_left      (in_left),
      .in_right     (in_right),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_rd      (data_rd),
      .data_l       (data_l),
      .data_r       (data_r),
      .level        (level),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   initial begin
      mck = 1'b0;
      forever #5 mck = ~mck;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model: update on each rising edge from the inputs that are presented.
   task automatic model_step();
      bit          rdy;
      bit          und;
      logic [63:0] pair;
      if (rst) begin
         q.delete();
         e_l   = 32'sd0;
         e_r   = 32'sd0;
         e_und = 1'b0;
         e_cnt = 16'd0;
         m_on  = 1'b1;
      end else begin
         rdy = (q.size() != DEPTH);
         und = data_rd && (q.size() == 0);
         if (data_rd && q.size() > 0) begin
            pair = q.pop_front();
            e_l  = pair[63:32];
            e_r  = pair[31:0];
         end else if (und) begin
`ifndef IIS_TX_FEEDER_HOLD_LAST_EN
            e_l = 32'sd0;
            e_r = 32'sd0;
`endif
         end
         if (in_valid && rdy) q.push_back({in_left, in_right});
         e_und = und;
         if (und && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      end
   endtask

   initial begin
      forever begin
         @(posedge mck);
         model_step();
      end
   end

   // Compare process: every DUT output against the model on each falling edge.
   initial begin
      forever begin
         @(negedge mck);
         if (m_on) begin
            chk("level",        32'(level),        32'(q.size()));
            chk("in_ready",     32'(in_ready),     32'(q.size() != DEPTH));
            chk("data_l",       data_l,            e_l);
            chk("data_r",       data_r,            e_r);
            chk("underrun",     32'(underrun),     32'(e_und));
            chk("underrun_cnt", 32'(underrun_cnt), 32'(e_cnt));
         end
      end
   end

   task automatic cyc(input bit v, input int l, input int r, input bit rd);
      in_valid = v;
      in_left  = l;
      in_right = r;
      data_rd  = rd;
      @(negedge mck);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b1, 99, 99, 1'b1);  // this push and request must be ignored
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_left  = 32'sd0;
      in_right = 32'sd0;
      data_rd  = 1'b0;
      cyc(1'b0, 0, 0, 1'b0);
      do_reset();

      // Push three pairs, then issue three spaced requests
      chk("lit_ready_after_rst", 32'(in_ready), 32'd1);
      chk("lit_level_after_rst", 32'(level), 32'd0);
      cyc(1'b1, 1, -1, 1'b0);
      cyc(1'b1, 2, -2, 1'b0);
      cyc(1'b1, 3, -3, 1'b0);
      chk("lit_level3", 32'(level), 32'd3);
      for (int k = 1; k <= 3; k++) begin
         cyc(1'b0, 0, 0, 1'b1);
         chk("lit_pop_l", data_l, k);
         chk("lit_pop_r", data_r, -k);
         repeat (63) cyc(1'b0, 0, 0, 1'b0);
         chk("lit_hold_l", data_l, k);
      end
      chk("lit_level0", 32'(level), 32'd0);

      // Underrun on the empty FIFO
      cyc(1'b0, 0, 0, 1'b1);
      chk("lit_und_pulse", 32'(underrun), 32'd1);
      chk("lit_und_cnt", 32'(underrun_cnt), 32'd1);
`ifdef IIS_TX_FEEDER_HOLD_LAST_EN
      chk("lit_und_l", data_l, 32'd3);
      chk("lit_und_r", data_r, -3);
`else
      chk("lit_und_l", data_l, 32'd0);
      chk("lit_und_r", data_r, 32'd0);
`endif
      cyc(1'b0, 0, 0, 1'b0);
      chk("lit_und_single", 32'(underrun), 32'd0);

      // Fill the FIFO; the 17th pair is accepted only after a request
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1'b1, 100 + i, -(100 + i), 1'b0);
      chk("lit_full_level", 32'(level), 32'd16);
      chk("lit_full_ready", 32'(in_ready), 32'd0);
      cyc(1'b1, 116, -116, 1'b0);
      chk("lit_full_hold", 32'(level), 32'd16);
      cyc(1'b1, 116, -116, 1'b1);
      chk("lit_full_pop_level", 32'(level), 32'd15);
      chk("lit_full_pop_l", data_l, 32'd100);
      cyc(1'b1, 116, -116, 1'b0);
      chk("lit_17th_in", 32'(level), 32'd16);
      repeat (16) cyc(1'b0, 0, 0, 1'b1);
      chk("lit_17th_out_l", data_l, 32'd116);
      chk("lit_17th_out_r", data_r, -116);

      // Simultaneous push and pop at level 5
      do_reset();
      for (int i = 1; i <= 5; i++) cyc(1'b1, 10 * i, -10 * i, 1'b0);
      cyc(1'b1, 60, -60, 1'b1);
      chk("lit_pp_level", 32'(level), 32'd5);
      chk("lit_pp_l", data_l, 32'd10);
      chk("lit_pp_r", data_r, -10);

      // Push and request together while empty
      do_reset();
      cyc(1'b1, 7, 8, 1'b1);
      chk("lit_e_und", 32'(underrun), 32'd1);
      chk("lit_e_level", 32'(level), 32'd1);
      cyc(1'b0, 0, 0, 1'b1);
      chk("lit_e_l", data_l, 32'd7);
      chk("lit_e_r", data_r, 32'd8);

      // Reset in mid-operation
      do_reset();
      repeat (3) cyc(1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 5 + i, 6 + i, 1'b0);
      chk("lit_pre_level", 32'(level), 32'd4);
      chk("lit_pre_cnt", 32'(underrun_cnt), 32'd3);
      do_reset();
      chk("lit_rst_level", 32'(level), 32'd0);
      chk("lit_rst_l", data_l, 32'd0);
      chk("lit_rst_r", data_r, 32'd0);
      chk("lit_rst_cnt", 32'(underrun_cnt), 32'd0);
      chk("lit_rst_ready", 32'(in_ready), 32'd1);

      // Randomized traffic with phases that bias toward full or toward empty
      for (int i = 0; i < 4000; i++) begin
         int pv;
         int pr;
         pv  = ((i / 400) % 2 == 0) ? 75 : 25;
         pr  = ((i / 400) % 2 == 0) ? 30 : 70;
         rst = ($urandom_range(0, 499) == 0);
         cyc($urandom_range(0, 99) < pv, int'($urandom), int'($urandom),
             $urandom_range(0, 99) < pr);
      end
      rst = 1'b0;
      cyc(1'b0, 0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
